// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit.
// One iteration per cycle, 32 iterations. The cycle after the last iteration
// applies the sign fixup and writes HI/LO. Synchronous active-high reset.
// Optional feature macro: MDU_DIV_EN adds the restoring divide datapath
// (ops 10/11). Without it, a start with op[1]=1 is not accepted.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for start; mthi/mtlo moves are accepted here only
// S_RUN  | 32 iterations, then sign fixup and HI/LO write
// S_DONE | done pulse cycle, still busy; returns to S_IDLE
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] read_data_1,
  input  logic [WIDTH-1:0] read_data_2,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial sum, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;

  logic               start_ok;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_res;
`ifdef MDU_DIV_EN
  logic               div_q, div_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   quo, rem;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Operand sign/magnitude conditioning for signed ops (op[0]=0) and start qualification.
  always_comb begin
    sign_a = ~op[0] & read_data_1[WIDTH-1];
    sign_b = ~op[0] & read_data_2[WIDTH-1];
    mag_a  = sign_a ? -read_data_1 : read_data_1;
    mag_b  = sign_b ? -read_data_2 : read_data_2;
`ifdef MDU_DIV_EN
    start_ok = start;
`else
    start_ok = start & ~op[1];
`endif
  end

  // Per-iteration arithmetic and final sign fixup of the accumulator.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_res = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
`ifdef MDU_DIV_EN
    // Trial subtract of the divisor from {remainder, next dividend bit}.
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    quo      = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem      = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
  end

  // Next-state and next-output computation for the control FSM and datapath.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
`ifdef MDU_DIV_EN
    div_d   = div_q;
    a_d     = a_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start_ok) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          neg_a_d = sign_a;
          neg_b_d = sign_b;
          acc_d   = {{WIDTH{1'b0}}, mag_b};
          opnd_d  = mag_a;
`ifdef MDU_DIV_EN
          div_d   = op[1];
          a_d     = read_data_1;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, mag_a};
            opnd_d = mag_b;
          end
`endif
        end else begin
          if (mthi) hi_d = read_data_1;
          if (mtlo) lo_d = read_data_1;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          {hi_d, lo_d} = mul_res;
`ifdef MDU_DIV_EN
          if (div_q) begin
            if (opnd_q == '0) begin
              hi_d = a_q;
              lo_d = '1;
            end else begin
              hi_d = rem;
              lo_d = quo;
            end
          end
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
          if (div_q) begin
            acc_d = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any operation without writing a result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
`ifdef MDU_DIV_EN
      div_q   <= 1'b0;
      a_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
`ifdef MDU_DIV_EN
      div_q   <= div_d;
      a_q     <= a_d;
`endif
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on posedge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request an operation; sampled in IDLE only.
REQ-005 SHALL have port op, input, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port read_data_1, input, 32: operand A (rs); dividend for DIV/DIVU; data for MTHI/MTLO.
REQ-007 SHALL have port read_data_2, input, 32: operand B (rt); divisor for DIV/DIVU.
REQ-008 SHALL have port mthi, input, 1: write read_data_1 into HI.
REQ-009 SHALL have port mtlo, input, 1: write read_data_1 into LO.
REQ-010 SHALL have port busy, output, 1: high while an operation runs.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have ports hi and lo, output, 32 each: HI/LO registers, registered outputs.

Function
REQ-013 SHALL implement the states IDLE, RUN and DONE.
REQ-014 SHALL, on start=1 in IDLE, latch op and both operands, clear the iteration counter and enter RUN.
REQ-015 SHALL execute exactly 32 iterations in RUN (one per cycle): shift-add for multiply, restoring shift-subtract for divide.
REQ-016 SHALL, after the 32nd iteration, write the results to HI/LO and enter DONE; done=1 for that one cycle, then return to IDLE.
REQ-017 SHALL meet this latency: start sampled at edge N -> busy=1 from N through N+32 -> hi/lo updated and done=1 after edge N+33.
REQ-018 SHALL hold busy=1 in RUN and DONE, and busy=0 in IDLE.
REQ-019 SHALL, for multiply, place result bits [63:32] in HI and [31:0] in LO.
REQ-020 SHALL compute MULT as signed two's-complement: operate on magnitudes and negate the 64-bit result when the operand signs differ.
REQ-021 SHALL compute MULTU as unsigned.
REQ-022 SHALL, for divide, place the quotient in LO and the remainder in HI.
REQ-023 SHALL make the DIV quotient truncate toward zero and give the remainder the sign of the dividend.
REQ-024 SHALL, on divide by zero, still take the full latency and produce HI=read_data_1 (latched) and LO=32'hFFFFFFFF.
REQ-025 SHALL, for signed DIV 32'h80000000 / 32'hFFFFFFFF, produce LO=32'h80000000 and HI=0.
REQ-026 SHALL ignore start while busy=1; the latched operands are unaffected.
REQ-027 SHALL, in IDLE, write HI on mthi=1 and LO on mtlo=1 at the next edge; both asserted SHALL write both.
REQ-028 SHALL ignore mthi/mtlo while busy=1.
REQ-029 SHALL give start priority over mthi/mtlo when they are asserted in the same IDLE cycle; the move is dropped.
REQ-030 SHALL change hi/lo only at DONE, on an accepted move, or on reset.

Reset
REQ-031 SHALL, on reset=1 at a posedge, force state=IDLE, busy=0, done=0, hi=0, lo=0 and clear the counter.
REQ-032 SHALL, on reset mid-RUN or in DONE, abort the operation with no result written; start in that same cycle SHALL be ignored.

Configuration
REQ-033 SHALL use the macro MDU_DIV_EN to include the divide datapath.
REQ-034 SHALL, with MDU_DIV_EN defined, execute op 10/11 as specified above.
REQ-035 SHALL, without MDU_DIV_EN, exclude the divide datapath; start with op[1]=1 is ignored (no RUN, busy stays 0, hi/lo unchanged), and multiply is unaffected.

Verification
REQ-036 SHALL cover signed multiply: MULT A=32'hFFFFFFFD (-3), B=5 -> done exactly 33 cycles after start, HI=32'hFFFFFFFF, LO=32'hFFFFFFF1.
REQ-037 SHALL cover unsigned multiply: MULTU A=B=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-038 SHALL cover divide (MDU_DIV_EN): DIV -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU 7/0 -> HI=7, LO=32'hFFFFFFFF.
REQ-039 SHALL cover busy behaviour: during MULT 6*7, start (A=1, B=1), mthi and mtlo pulsed at RUN cycle 5 -> all ignored, final LO=42, HI=0; next idle mthi with read_data_1=32'h1234 -> HI=32'h1234 one cycle later.
REQ-040 SHALL cover reset mid-operation: reset at RUN cycle 10 -> next cycle busy=0, hi=lo=0, and no done pulse follows.
REQ-041 SHALL cover the divide-excluded build: without MDU_DIV_EN, start with op=10 -> busy stays 0 and hi/lo are unchanged over 40 cycles.
